if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0000, value driven on instruction when no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 EX_kick_up  input  1  downstream has consumed the presented instruction this cycle.
REQ-006 EX_flush  input  1  redirect request; discard all fetch state.
REQ-007 EX_branch_target  input  32  new PC, valid when EX_flush=1.
REQ-008 imem_req  output  1  one-cycle fetch request pulse.
REQ-009 imem_addr  output  32  fetch address, valid when imem_req=1.
REQ-010 imem_valid  input  1  response strobe from instruction memory.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-012 instruction  output  32  held instruction presented to the decode stage.
REQ-013 IF_pc  output  32  PC of the held instruction.
REQ-014 IF_valid  output  1  instruction/IF_pc hold a real instruction.
REQ-015 IF_ID_kick_up  output  1  one-cycle pulse when the first valid instruction after reset or flush is presented.

Function
REQ-016 FSM states SEND, WAIT, HOLD, DISCARD; all outputs registered except imem_req/imem_addr, which are decoded from state and fetch_pc.
REQ-017 SEND: imem_req=1, imem_addr=fetch_pc; next state WAIT.
REQ-018 WAIT: on imem_valid, capture imem_rdata into instruction, fetch_pc into IF_pc, set IF_valid=1, go HOLD; otherwise stay WAIT (no timeout).
REQ-019 HOLD: instruction held stable; on EX_kick_up, fetch_pc <= fetch_pc + 4, IF_valid <= 0, go SEND.
REQ-020 Fetch latency: minimum 2 cycles from imem_req to IF_valid (1 cycle memory latency); at most one request outstanding.
REQ-021 IF_ID_kick_up pulses exactly once, in the cycle after IF_valid rises, only when first_flag=1; first_flag is set by reset or flush and cleared by that pulse.
REQ-022 EX_kick_up outside HOLD is ignored.
REQ-023 fetch_pc + 4 wraps modulo 2^32; imem_addr bits [1:0] always 2'b00.
REQ-024 EX_flush (any state) has priority over all other events: fetch_pc <= {EX_branch_target[31:2],2'b00}, IF_valid <= 0, instruction <= NOP_INSN, first_flag <= 1.
REQ-025 Flush next state: DISCARD if a request is outstanding (state WAIT without imem_valid this cycle, or SEND); otherwise SEND.
REQ-026 DISCARD: drop the next imem_valid response without capture, then SEND; EX_flush in DISCARD reloads fetch_pc and stays DISCARD.
REQ-027 imem_valid arriving in SEND, HOLD or when no request is outstanding is ignored.

Reset
REQ-028 While reset=0: state=SEND on release, fetch_pc=RESET_PC, IF_pc=0, instruction=NOP_INSN, IF_valid=0, IF_ID_kick_up=0, first_flag=1, imem_req=0.
REQ-029 Reset mid-fetch abandons the outstanding request; a stale imem_valid in the first cycle after release is ignored.

Structure
REQ-030 Opcode constants, NOP_INSN default and the FSM state encoding live in the shared pipeline package also used by the decode and execute stages.
REQ-031 One sub-module, if_pc_gen, holds fetch_pc, its +4 increment and flush load; the FSM stays in if_fetch.

Verification
REQ-032 Reset release, memory returns 32'h00500093 one cycle after request at 0x0 -> IF_valid=1, IF_pc=0x0, single IF_ID_kick_up pulse.
REQ-033 Three EX_kick_up pulses in HOLD -> imem_addr sequence 0x4, 0x8, 0xC; no IF_ID_kick_up pulses.
REQ-034 EX_flush with target 0x100 during WAIT, late response 0xDEADBEEF -> response dropped; next imem_addr=0x100; IF_ID_kick_up pulses again.
REQ-035 fetch_pc=0xFFFFFFFC, EX_kick_up -> next imem_addr=0x00000000.
REQ-036 Memory latency 5 cycles; EX_kick_up asserted during WAIT -> ignored; IF_valid rises one cycle after imem_valid.
REQ-037 Reset asserted in WAIT, imem_valid in first cycle after release -> IF_valid stays 0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared pipeline package: opcode constants, default NOP encoding,
// fetch FSM state encoding and a word-alignment helper.
// Used by the fetch, decode and execute stages.
package if_fetch_pkg;

  // RV32I major opcodes (insn[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    SEND    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC generator: holds fetch_pc, steps it by 4 (wrapping modulo 2^32)
// and loads a word-aligned redirect target.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   load        - redirect; load_pc takes priority over step
//   load_pc     - redirect target (low two bits dropped)
//   step        - advance to the next sequential word
//   fetch_pc    - current fetch address, always word aligned
module if_pc_gen
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        step,
  output logic [31:0] fetch_pc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= word_align(RESET_PC);
    end else if (load) begin
      fetch_pc <= word_align(load_pc);
    end else if (step) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory, holds the returned word for decode until it is consumed, and
// handles redirects, including dropping a response still in flight.
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   EX_kick_up                      - decode consumed the held instruction
//   EX_flush, EX_branch_target      - redirect request and new PC
//   imem_req, imem_addr             - one-cycle fetch request and address
//   imem_valid, imem_rdata          - memory response strobe and data
//   instruction, IF_pc, IF_valid    - held instruction, its PC, valid flag
//   IF_ID_kick_up                   - pulse on first instruction after reset/flush
//
// state   | meaning
// SEND    | request driven this cycle at fetch_pc
// WAIT    | request outstanding, waiting for imem_valid
// HOLD    | instruction held for decode until EX_kick_up
// DISCARD | redirected with a request in flight; drop its response
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_kick_up,
  input  logic        EX_flush,
  input  logic [31:0] EX_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] IF_pc,
  output logic        IF_valid,
  output logic        IF_ID_kick_up
);

  if_state_e   state;
  if_state_e   state_next;
  logic        capture;
  logic        consume;
  logic        first_flag;
  logic [31:0] fetch_pc;

  if_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (EX_flush),
    .load_pc (EX_branch_target),
    .step    (consume),
    .fetch_pc(fetch_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SEND;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    consume    = 1'b0;
    if (EX_flush) begin
      // A request is still in flight unless WAIT sees its response now.
      case (state)
        SEND:    state_next = DISCARD;
        WAIT:    state_next = imem_valid ? SEND : DISCARD;
        DISCARD: state_next = DISCARD;
        default: state_next = SEND;
      endcase
    end else begin
      case (state)
        SEND: state_next = WAIT;
        WAIT: begin
          if (imem_valid) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (EX_kick_up) begin
            consume    = 1'b1;
            state_next = SEND;
          end
        end
        DISCARD: begin
          if (imem_valid) begin
            state_next = SEND;
          end
        end
        default: state_next = SEND;
      endcase
    end
  end

  // Gated by reset so no request escapes while reset is held.
  assign imem_req  = reset && (state == SEND);
  assign imem_addr = word_align(fetch_pc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction   <= NOP_INSN;
      IF_pc         <= 32'h0000_0000;
      IF_valid      <= 1'b0;
      IF_ID_kick_up <= 1'b0;
      first_flag    <= 1'b1;
    end else if (EX_flush) begin
      instruction   <= NOP_INSN;
      IF_valid      <= 1'b0;
      IF_ID_kick_up <= 1'b0;
      first_flag    <= 1'b1;
    end else begin
      IF_ID_kick_up <= 1'b0;
      if (capture) begin
        instruction <= imem_rdata;
        IF_pc       <= fetch_pc;
        IF_valid    <= 1'b1;
      end else if (consume) begin
        instruction <= NOP_INSN;
        IF_valid    <= 1'b0;
      end
      // IF_valid is high for the first time since reset/flush: pulse once.
      if (IF_valid && first_flag) begin
        IF_ID_kick_up <= 1'b1;
        first_flag    <= 1'b0;
      end
    end
  end

endmodule
